// File: rtl/tinyalu_pkg.sv
// Shared types and constants for the tinyalu arbiter and its helpers.
// Opcode and FSM encodings, plus operand/result widths.
package tinyalu_pkg;

  localparam int OPW = 3;
  localparam int DW  = 8;
  localparam int RW  = 16;

  typedef enum logic [OPW-1:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_MUL = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_e;

  // True for opcodes that actually need the ALU; NOP and 5-7 are answered locally.
  function automatic logic op_starts_alu(input logic [OPW-1:0] op);
    return (op >= OP_ADD) && (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after ptr,
// wrapping modulo NREQ. Produces a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  function automatic int wrap_idx(input int p, input int k);
    return (p + k) % NREQ;
  endfunction

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!any && req[wrap_idx(int'(ptr), k)]) begin
        grant[wrap_idx(int'(ptr), k)] = 1'b1;
        idx = IDW'(wrap_idx(int'(ptr), k));
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Shares a single tinyalu between NREQ requesters: round-robin grant, ALU
// start/done handshake with a watchdog, and one tagged response channel.
module tinyalu_arbiter
  import tinyalu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*DW-1:0]  req_a,
  input  logic [NREQ*DW-1:0]  req_b,
  input  logic [NREQ*OPW-1:0] req_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [RW-1:0]     resp_result,
  output logic              resp_err,
  output logic [DW-1:0]     alu_a,
  output logic [DW-1:0]     alu_b,
  output logic [OPW-1:0]    alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [RW-1:0]     alu_result,
  output logic              busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e           state;
  logic [IDW-1:0]   rr_ptr;
  logic [CW-1:0]    wdog;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             any_req;
  logic [DW-1:0]    sel_a;
  logic [DW-1:0]    sel_b;
  logic [OPW-1:0]   sel_op;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .any   (any_req)
  );

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a  = req_a[i*DW +: DW];
        sel_b  = req_b[i*DW +: DW];
        sel_op = req_op[i*OPW +: OPW];
      end
    end
  end

  // Ready is held low during reset so no handshake can complete while the FSM is being cleared.
  assign req_ready = (state == S_IDLE && reset_n) ? grant : '0;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      rr_ptr      <= IDW'(NREQ - 1);
      wdog        <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_start   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            alu_a       <= sel_a;
            alu_b       <= sel_b;
            alu_op      <= sel_op;
            resp_id     <= grant_idx;
            rr_ptr      <= grant_idx;
            wdog        <= '0;
            resp_result <= '0;
            resp_err    <= 1'b0;
            if (op_starts_alu(sel_op)) begin
              alu_start <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= (sel_op != OP_NOP);
              state      <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          // done is checked first so it wins over a coincident timeout
          if (alu_done) begin
            alu_start   <= 1'b0;
            resp_result <= alu_result;
            resp_err    <= 1'b0;
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end else if (wdog == CW'(TIMEOUT - 1)) begin
            alu_start   <= 1'b0;
            resp_result <= '0;
            resp_err    <= 1'b1;
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end else begin
            wdog <= wdog + CW'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed bench for tinyalu_arbiter with a behavioural tinyalu model
// (1-cycle ADD/AND/XOR, 3-cycle MUL, done gated by done_en).
module tb_tinyalu_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a = '0;
  logic [NREQ*8-1:0] req_b = '0;
  logic [NREQ*3-1:0] req_op = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [IDW-1:0]    resp_id;
  logic [15:0]       resp_result;
  logic              resp_err;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [2:0]        alu_op;
  logic              alu_start;
  logic              alu_done;
  logic [15:0]       alu_result;
  logic              busy;

  tinyalu_arbiter #(
    .NREQ    (NREQ),
    .IDW     (IDW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // tinyalu model
  logic        done_en = 1'b1;
  logic        alu_done_m = 1'b0;
  logic        active = 1'b0;
  int          cnt = 0;
  logic [15:0] alu_res_m = '0;

  function automatic logic [15:0] calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] a16;
    logic [15:0] b16;
    a16 = {8'h00, a};
    b16 = {8'h00, b};
    case (op)
      3'd1:    return a16 + b16;
      3'd2:    return a16 & b16;
      3'd3:    return a16 ^ b16;
      3'd4:    return a16 * b16;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_done_m <= 1'b0;
    if (!alu_start) begin
      active <= 1'b0;
      cnt    <= 0;
    end else if (!active) begin
      active <= 1'b1;
      if (alu_op == 3'd4) cnt <= 2;
      else begin
        alu_done_m <= 1'b1;
        alu_res_m  <= calc(alu_op, alu_a, alu_b);
      end
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        alu_done_m <= 1'b1;
        alu_res_m  <= calc(alu_op, alu_a, alu_b);
      end
    end
  end

  assign alu_done   = alu_done_m & done_en;
  assign alu_result = alu_res_m;

  // start monitor: total start-high cycles and short low gaps between episodes
  int   start_cyc = 0;
  int   low_run = 0;
  int   gap_bad = 0;
  logic seen_start = 1'b0;
  logic prev_start = 1'b0;

  always @(negedge clk) begin
    if (alu_start) begin
      if (!prev_start && seen_start && low_run < 2) gap_bad <= gap_bad + 1;
      seen_start <= 1'b1;
      low_run    <= 0;
      start_cyc  <= start_cyc + 1;
    end else begin
      low_run <= low_run + 1;
    end
    prev_start <= alu_start;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n    = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic run_op(input string tag, input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [15:0] eres, input logic eerr,
                        input int elat, input int estart, input int hold, input logic [NREQ-1:0] bg);
    int          sc0;
    int          lat;
    bit          acc;
    logic [IDW-1:0] id0;
    logic [15:0] r0;
    logic        e0;
    @(posedge clk); #1;
    req_a[idx*8 +: 8]  = a;
    req_b[idx*8 +: 8]  = b;
    req_op[idx*3 +: 3] = op;
    req_valid[idx]     = 1'b1;
    sc0 = start_cyc;
    acc = 1'b0;
    for (int w = 0; w < 20 && !acc; w++) begin
      @(negedge clk);
      if (req_ready != '0) acc = 1'b1;
    end
    chk({tag, ".grant"}, 64'(req_ready), 64'(NREQ'(1) << idx));
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    req_valid      = req_valid | bg;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, ".operands"}, 64'({alu_a, alu_b, alu_op}), 64'({a, b, op}));
      if (resp_valid) lat = k;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(elat));
    chk({tag, ".id"}, 64'(resp_id), 64'(idx));
    chk({tag, ".result"}, 64'(resp_result), 64'(eres));
    chk({tag, ".err"}, 64'(resp_err), 64'(eerr));
    chk({tag, ".start_cycles"}, 64'(start_cyc - sc0), 64'(estart));
    id0 = resp_id;
    r0  = resp_result;
    e0  = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("%s.hold%0d", tag, h), 64'({resp_valid, resp_id, resp_result, resp_err, req_ready}),
          64'({1'b1, id0, r0, e0, NREQ'(0)}));
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = req_valid & ~bg;
    @(negedge clk);
    chk({tag, ".idle"}, 64'({resp_valid, busy}), 64'(0));
  endtask

  typedef struct {
    int          idx;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [15:0] res;
    logic        err;
    int          lat;
    int          starts;
  } vec_t;

  vec_t        vecs[10];
  logic [15:0] rr_res[4];
  int          ng;
  int          nr;
  int          seen_bad;
  bit          acc2;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vecs[0] = '{2, 8'h12, 8'h34, 3'd1, 16'h0046, 1'b0, 3, 2};
    vecs[1] = '{0, 8'hFF, 8'hFF, 3'd4, 16'hFE01, 1'b0, 5, 4};
    vecs[2] = '{1, 8'h55, 8'hAA, 3'd0, 16'h0000, 1'b0, 1, 0};
    vecs[3] = '{3, 8'h11, 8'h22, 3'd6, 16'h0000, 1'b1, 1, 0};
    vecs[4] = '{1, 8'hF0, 8'h3C, 3'd3, 16'h00CC, 1'b0, 3, 2};
    vecs[5] = '{3, 8'hA5, 8'h0F, 3'd2, 16'h0005, 1'b0, 3, 2};
    vecs[6] = '{0, 8'h01, 8'h01, 3'd5, 16'h0000, 1'b1, 1, 0};
    vecs[7] = '{2, 8'hFF, 8'h01, 3'd1, 16'h0100, 1'b0, 3, 2};
    vecs[8] = '{3, 8'h10, 8'h10, 3'd4, 16'h0100, 1'b0, 5, 4};
    vecs[9] = '{2, 8'h80, 8'h02, 3'd7, 16'h0000, 1'b1, 1, 0};
    rr_res  = '{16'h0003, 16'h0030, 16'h00CC, 16'h0100};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.outputs", 64'({req_ready, resp_valid, resp_id, resp_result, resp_err,
                              alu_a, alu_b, alu_op, alu_start, busy}), 64'(0));
    #1 reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("v%0d", i), vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].op,
             vecs[i].res, vecs[i].err, vecs[i].lat, vecs[i].starts, 0, '0);

    // round robin with all requesters valid and the response side always ready
    do_reset();
    @(posedge clk); #1;
    req_a      = {8'h10, 8'hF0, 8'hF0, 8'h01};
    req_b      = {8'h10, 8'h3C, 8'h3C, 8'h02};
    req_op     = {3'd4, 3'd3, 3'd2, 3'd1};
    resp_ready = 1'b1;
    req_valid  = 4'hF;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 200 && nr < 6; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk($sformatf("rr.grant%0d", ng), 64'(req_ready), 64'(NREQ'(1) << (ng % 4)));
        ng++;
      end
      if (resp_valid) begin
        chk($sformatf("rr.resp%0d", nr), 64'({resp_id, resp_result, resp_err}),
            64'({IDW'(nr % 4), rr_res[nr % 4], 1'b0}));
        nr++;
      end
    end
    chk("rr.responses", 64'(nr), 64'(6));
    @(posedge clk); #1;
    req_valid  = '0;
    resp_ready = 1'b0;

    // watchdog abort, then a normal operation afterwards
    do_reset();
    done_en = 1'b0;
    run_op("timeout", 2, 8'h12, 8'h34, 3'd1, 16'h0000, 1'b1, TIMEOUT + 1, TIMEOUT, 0, '0);
    done_en = 1'b1;
    run_op("after_timeout", 0, 8'h05, 8'h06, 3'd1, 16'h000B, 1'b0, 3, 2, 0, '0);

    // backpressure with another requester waiting
    run_op("backpressure", 2, 8'h21, 8'h03, 3'd4, 16'h0063, 1'b0, 5, 4, 5, 4'b0001);

    // reset pulsed mid-ISSUE
    do_reset();
    done_en = 1'b0;
    @(posedge clk); #1;
    req_a[15:8]  = 8'h07;
    req_b[15:8]  = 8'h09;
    req_op[5:3]  = 3'd4;
    req_valid[1] = 1'b1;
    acc2 = 1'b0;
    for (int w = 0; w < 20 && !acc2; w++) begin
      @(negedge clk);
      if (req_ready != '0) acc2 = 1'b1;
    end
    chk("midreset.grant", 64'(req_ready), 64'(4'b0010));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("midreset.in_issue", 64'({busy, alu_start}), 64'(2'b11));
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset.outputs", 64'({req_ready, resp_valid, resp_id, resp_result, resp_err,
                                 alu_a, alu_b, alu_op, alu_start, busy}), 64'(0));
    #1 reset_n = 1'b1;
    done_en  = 1'b1;
    seen_bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (resp_valid || alu_start || busy) seen_bad++;
    end
    chk("midreset.no_stale", 64'(seen_bad), 64'(0));
    run_op("after_reset", 3, 8'h0F, 8'hF0, 3'd3, 16'h00FF, 1'b0, 3, 2, 0, '0);

    chk("start_gap", 64'(gap_bad), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tinyalu_arbiter.md
Name: tinyalu_arbiter

Overview:
- Shares one tinyalu instance between NREQ independent requesters.
- Accepts operand/op requests over valid/ready channels and grants them round-robin.
- Drives the ALU start/done handshake, bounded by a watchdog, and returns each result on a single tagged response channel with backpressure.
- Sits between stimulus BFMs (or upstream logic) and the tinyalu inside the bench top.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, response id width; must satisfy 2**IDW >= NREQ.
- TIMEOUT, 16, maximum cycles start may be held without done before abort.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_a  in  NREQ*8  operand A, requester i at [8i+7:8i]
- req_b  in  NREQ*8  operand B, same packing
- req_op  in  NREQ*3  opcode, requester i at [3i+2:3i]
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  IDW  index of the requester that owns the response
- resp_result  out  16  ALU result
- resp_err  out  1  response is an invalid-op or timeout error
- alu_a  out  8  to tinyalu A
- alu_b  out  8  to tinyalu B
- alu_op  out  3  to tinyalu op
- alu_start  out  1  to tinyalu start
- alu_done  in  1  from tinyalu done
- alu_result  in  16  from tinyalu result
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer = NREQ-1, so requester 0 wins first. Reset applies in any state, including mid-operation; an in-flight request is dropped with no response.
- Opcodes: 0 NOP, 1 ADD, 2 AND, 3 XOR, 4 MUL. Opcodes 5-7 are invalid.
- IDLE:
  - If any req_valid is high, grant the first valid requester after the rr pointer, wrapping modulo NREQ.
  - req_ready[g] is combinational and high for that cycle only; the handshake completes that cycle.
  - Latch a/b/op into alu_a/alu_b/alu_op and g into resp_id; rr pointer <= g.
  - Next state:
    - op 1-4 -> ISSUE.
    - op 0 -> RESP with result 0, err 0; the ALU is not started.
    - op 5-7 -> RESP with result 0, err 1.
- ISSUE:
  - alu_start is registered and high every cycle in ISSUE, starting the cycle after accept.
  - Watchdog counter is cleared on entry and increments each ISSUE cycle.
  - On the cycle alu_done=1 is sampled: resp_result <= alu_result, err 0, alu_start <= 0, go to RESP.
  - If the counter reaches TIMEOUT-1 without done: alu_start <= 0, result 0, err 1, go to RESP.
  - If done and the timeout coincide, done wins.
- RESP:
  - resp_valid is high; resp_id, resp_result and resp_err are stable while resp_valid && !resp_ready.
  - On resp_ready: resp_valid <= 0, go to IDLE.
  - The next grant happens no earlier than the cycle after the response handshake. This guarantees alu_start is low for at least 2 cycles between operations.
- alu_a, alu_b and alu_op hold their values from accept until the next accept.
- Latency, accept to resp_valid:
  - ADD/AND/XOR: 3 cycles (1 to raise start, plus 1-cycle ALU done, plus 1 to register).
  - MUL: ALU latency + 2.
  - NOP and invalid ops: 1 cycle.
- req_valid is allowed to drop without a handshake. The arbiter never stores unaccepted requests.

Decomposition:
- Package tinyalu_pkg holds:
  - the opcode enum (NOP, ADD, AND, XOR, MUL);
  - the state enum (IDLE, ISSUE, RESP);
  - constants OPW=3, DW=8, RW=16.
- Sub-module rr_arbiter: combinational round-robin pick from a request vector and pointer. Outputs a one-hot grant and a binary index. It is reusable by other shared-resource blocks.

Test Plan:
- Single ADD from requester 2, A=8'h12, B=8'h34 -> exactly one start episode; resp_valid 3 cycles after accept; resp_id=2, resp_result=16'h0046, resp_err=0.
- MUL from requester 0, A=B=8'hFF -> resp_result=16'hFE01; alu_start held until done; start low for ≥2 cycles before the next op.
- All 4 requesters valid continuously with resp_ready=1 -> grant order 0,1,2,3,0,1; no requester is starved; each resp_id matches the owner's operands (e.g. XOR 8'hF0^8'h3C=16'h00CC).
- NOP from requester 1, and op 3'd6 from requester 3 -> alu_start never asserted; responses carry result 0 with err=0 and err=1 respectively.
- ALU model with done tied to 0 -> start drops after TIMEOUT cycles; response err=1, result 0; the arbiter returns to IDLE and serves the next request normally.
- Two cases:
  - resp_ready held low 5 cycles: response fields stable and no new grant.
  - reset_n pulsed low mid-ISSUE: all outputs 0 next cycle and no stale response after reset.
